// File: rtl/cpu_reset_sequencer_if.sv
// cpu_reset_sequencer_if
//   Groups the reset sequencer's sideband signals so the core-side wrapper and
//   the sequencer share one bundle.
//   Inputs to the sequencer : pll_locked, swi_resetreq (both async to clk),
//                             cpu_resettaken, clear_timeout (clk domain)
//   Outputs of the sequencer: core_reset_n, cpu_resetrequest, busy, timeout_flag
//   modport slave  : the sequencer itself
//   modport master : whatever drives the inputs / observes the outputs
interface cpu_reset_sequencer_if;
  logic pll_locked;
  logic swi_resetreq;
  logic cpu_resettaken;
  logic clear_timeout;
  logic core_reset_n;
  logic cpu_resetrequest;
  logic busy;
  logic timeout_flag;

  modport slave (
    input  pll_locked, swi_resetreq, cpu_resettaken, clear_timeout,
    output core_reset_n, cpu_resetrequest, busy, timeout_flag
  );

  modport master (
    output pll_locked, swi_resetreq, cpu_resettaken, clear_timeout,
    input  core_reset_n, cpu_resetrequest, busy, timeout_flag
  );
endinterface

// File: rtl/cpu_reset_sequencer.sv
// cpu_reset_sequencer
//   Sits in front of the Qsys core's reset inputs. Holds the core in reset
//   until the PLL has been locked for LOCK_HOLD cycles, turns a software reset
//   request level into a handshaked, minimum-width Nios II reset request, and
//   escalates to a hard core reset if the CPU never reports resettaken.
// Ports
//   clk    : core clock
//   reset  : asynchronous active-high reset
//   bus    : cpu_reset_sequencer_if.slave
//            in  pll_locked, swi_resetreq (async), cpu_resettaken, clear_timeout
//            out core_reset_n, cpu_resetrequest, busy, timeout_flag (all registered)
module cpu_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_HOLD     = 64,
  parameter int REQ_HOLD      = 16,
  parameter int TAKEN_TIMEOUT = 4096,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  cpu_reset_sequencer_if.slave    bus
);

  localparam logic [CNT_W-1:0] LOCK_RLD  = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_RLD  = CNT_W'(REQ_HOLD - 1);
  localparam logic [CNT_W-1:0] TAKEN_RLD = CNT_W'(TAKEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    BOOT, IDLE, REQ, HOLD, ESCALATE, RELEASE
  } state_t;

  // synchronizers for the two asynchronous inputs
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_s_dly_q;
  logic                   lock_s;
  logic                   req_s;
  logic                   req_rise;

  assign lock_s   = lock_sync_q[SYNC_STAGES-1];
  assign req_s    = req_sync_q[SYNC_STAGES-1];
  assign req_rise = req_s & ~req_s_dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_sync_q <= '0;
      req_sync_q  <= '0;
      req_s_dly_q <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], bus.swi_resetreq};
      req_s_dly_q <= req_s;
    end
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_dec_d;
  logic             core_rst_n_q;
  logic             req_q;
  logic             busy_q;
  logic             tflag_q;

  // saturating decrement: the shared counter never wraps
  assign cnt_dec_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      cnt_q        <= LOCK_RLD;
      core_rst_n_q <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b1;
      tflag_q      <= 1'b0;
    end else begin
      // clear first so a same-cycle escalation set below overrides it
      if (bus.clear_timeout) tflag_q <= 1'b0;

      if (!lock_s && state_q != BOOT) begin
        // lock loss beats every other transition
        state_q      <= BOOT;
        cnt_q        <= LOCK_RLD;
        core_rst_n_q <= 1'b0;
        req_q        <= 1'b0;
        busy_q       <= 1'b1;
      end else begin
        case (state_q)
          BOOT: begin
            if (!lock_s) begin
              cnt_q <= LOCK_RLD;
            end else if (cnt_q == '0) begin
              state_q      <= IDLE;
              core_rst_n_q <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              cnt_q <= cnt_dec_d;
            end
          end
          IDLE: begin
            if (req_rise) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
              cnt_q   <= TAKEN_RLD;
            end
          end
          REQ: begin
            if (bus.cpu_resettaken) begin
              state_q <= HOLD;
              cnt_q   <= HOLD_RLD;
            end else if (cnt_q == '0) begin
              state_q      <= ESCALATE;
              req_q        <= 1'b0;
              core_rst_n_q <= 1'b0;
              cnt_q        <= LOCK_RLD;
              tflag_q      <= 1'b1;
            end else begin
              cnt_q <= cnt_dec_d;
            end
          end
          HOLD: begin
            if (cnt_q == '0) begin
              state_q <= RELEASE;
              req_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_dec_d;
            end
          end
          ESCALATE: begin
            if (cnt_q == '0) begin
              state_q      <= RELEASE;
              core_rst_n_q <= 1'b1;
            end else begin
              cnt_q <= cnt_dec_d;
            end
          end
          RELEASE: begin
            // a request still held high must be seen low before re-arming
            if (!req_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q      <= BOOT;
            cnt_q        <= LOCK_RLD;
            core_rst_n_q <= 1'b0;
            req_q        <= 1'b0;
            busy_q       <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.core_reset_n     = core_rst_n_q;
  assign bus.cpu_resetrequest = req_q;
  assign bus.busy             = busy_q;
  assign bus.timeout_flag     = tflag_q;

endmodule
